rv_pipe_ctrl: RTL and testbench
===============================

Name: rv_pipe_ctrl

Overview:
Pipeline sequencer for the fetch/decode/execute/memory stages of the RV core. It generates stall and flush strobes for each stage from three sources:
- load-use hazards against the instruction in decode
- PC redirects resolved in execute
- wait states on the data-memory handshake
A small FSM holds multi-cycle conditions (memory wait, extended redirect flush) and a watchdog aborts hung memory accesses.

Parameters:
FLUSH_CYCLES, 1, cycles o_dec_flush stays asserted per redirect (1..4)
MEM_TIMEOUT, 16, max wait cycles for i_mem_ready before abort; 0 disables the watchdog
TMO_W, 5, width of the wait counter; must satisfy 2**TMO_W > MEM_TIMEOUT

Ports:
i_clk  in  1  core clock
i_reset_n  in  1  asynchronous active-low reset
i_dec_rs1  in  5  rs1 of instruction in decode
i_dec_rs2  in  5  rs2 of instruction in decode
i_ex_rd  in  5  rd of instruction in execute
i_ex_mem_read  in  1  execute instruction is a load
i_ex_pc_change  in  1  execute resolved taken branch/jump (redirect)
i_mem_req  in  1  memory stage has an active data access
i_mem_ready  in  1  data memory completes access this cycle
o_fetch_stall  out  1  hold PC/fetch register
o_dec_stall  out  1  hold decode register (drives decode i_stall)
o_dec_flush  out  1  clear decode register (drives decode i_flush)
o_ex_stall  out  1  hold execute register
o_ex_flush  out  1  insert bubble into execute
o_mem_stall  out  1  hold memory stage
o_mem_err  out  1  one-cycle pulse: watchdog abort
o_state  out  2  current FSM state (debug)

Behaviour:
- Reset (i_reset_n=0, async):
  - state=RUN; wait counter=0; redirect counter=0.
  - While reset is asserted: o_dec_flush=1, o_ex_flush=1; all stalls=0; o_mem_err=0.
- States: RUN=0, MEM_WAIT=1, REDIRECT=2. Encoding 3 is illegal; it returns to RUN next cycle with no outputs asserted.
- Priority per cycle: memory wait > redirect > load-use.
- mem_hold = i_mem_req & !i_mem_ready (in RUN), or !i_mem_ready (in MEM_WAIT).
- When mem_hold is true:
  - o_fetch_stall=o_dec_stall=o_ex_stall=o_mem_stall=1 combinationally; no flushes.
  - RUN->MEM_WAIT. Wait counter increments each MEM_WAIT cycle.
  - i_mem_ready=1 in MEM_WAIT: stalls drop that same cycle; ->RUN; counter cleared.
- Watchdog (MEM_TIMEOUT>0): when the counter reaches MEM_TIMEOUT in MEM_WAIT:
  - o_mem_err=1 for that cycle and stalls drop.
  - ->RUN; counter cleared. An i_mem_ready in that same cycle is treated as completion, with no error.
- Redirect (i_ex_pc_change=1, no mem_hold):
  - o_dec_flush=1 and o_ex_flush=1 the same cycle.
  - If FLUSH_CYCLES>1: ->REDIRECT for FLUSH_CYCLES-1 further cycles with o_dec_flush=1 only, then ->RUN.
  - A redirect arriving during REDIRECT restarts the count.
  - A redirect coincident with mem_hold is deferred. Execute is frozen, so the input persists and is serviced in the cycle the memory completes.
- Load-use (RUN, no mem_hold, no redirect): i_ex_mem_read=1, i_ex_rd!=0, and i_ex_rd equals i_dec_rs1 or i_dec_rs2.
  - o_fetch_stall=o_dec_stall=1 and o_ex_flush=1 for exactly that cycle.
  - Next cycle the load has left execute, so the hazard self-clears.
- All stall/flush outputs are combinational from state plus inputs (zero latency). State and counters are registered.

Decomposition:
- Shared core package gets:
  - the FSM state typedef (2-bit enum RUN/MEM_WAIT/REDIRECT)
  - the register-index width constant (5)
- One sub-module, rv_hazard_detect: purely combinational load-use comparator. Inputs rs1/rs2/rd/mem_read; output hazard. It is reused later for forwarding.

Test Plan:
- Reset mid-MEM_WAIT (counter=7) -> state RUN, counter 0 immediately; flushes=1, stalls=0 while low.
- ex load rd=5, dec rs2=5 -> one cycle: o_fetch_stall=o_dec_stall=o_ex_flush=1. Repeat with rd=0 -> no stall.
- i_mem_req=1, i_mem_ready low 3 cycles then high -> all stalls high 3 cycles, low on the ready cycle, state RUN after; o_mem_err never set.
- MEM_TIMEOUT=16, ready never asserts -> o_mem_err pulses on the 16th MEM_WAIT cycle, stalls drop that cycle. With MEM_TIMEOUT=0 -> stalls persist indefinitely.
- FLUSH_CYCLES=3, i_ex_pc_change pulse -> o_dec_flush high 3 consecutive cycles, o_ex_flush high 1 cycle; second redirect on cycle 2 -> 3 more flush cycles.
- Redirect + load-use + mem_hold in the same cycle -> only stalls. On the ready cycle: redirect flushes, no load-use stall.

Source files
------------

// File: rtl/rv_pipe_ctrl_pkg.sv
// rv_pipe_ctrl_pkg: shared pipeline-control types and core constants
package rv_pipe_ctrl_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REDIRECT = 2'd2} state_t;
endpackage

// File: rtl/rv_pipe_ctrl_hazard.sv
// rv_hazard_detect: combinational load-use comparator between execute and decode
module rv_hazard_detect
  import rv_pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             mem_read,
  output logic             hazard
);
  assign hazard = mem_read && rd != '0 && (rd == rs1 || rd == rs2);
endmodule

// File: rtl/rv_pipe_ctrl.sv
// rv_pipe_ctrl: stall/flush sequencer for memory waits, execute redirects and load-use hazards
module rv_pipe_ctrl
  import rv_pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 16,
  parameter int TMO_W        = 5
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [REG_W-1:0] i_dec_rs1,
  input  logic [REG_W-1:0] i_dec_rs2,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_pc_change,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_fetch_stall,
  output logic             o_dec_stall,
  output logic             o_dec_flush,
  output logic             o_ex_stall,
  output logic             o_ex_flush,
  output logic             o_mem_stall,
  output logic             o_mem_err,
  output logic [1:0]       o_state
);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
  localparam logic [1:0] RC_INIT = 2'(FLUSH_CYCLES - 1);
  state_t state, nxt;
  logic [TMO_W-1:0] cnt, cnt_nxt;
  logic [1:0] rcnt, rcnt_nxt;
  logic hazard, legal, hold, tmo, stall, lu_stall, dec_flush, ex_flush;
  rv_hazard_detect u_hazard (
    .rs1      (i_dec_rs1),
    .rs2      (i_dec_rs2),
    .rd       (i_ex_rd),
    .mem_read (i_ex_mem_read),
    .hazard   (hazard)
  );
  assign legal = state inside {RUN, MEM_WAIT, REDIRECT};
  assign hold  = state == MEM_WAIT ? !i_mem_ready : legal && i_mem_req && !i_mem_ready;
  // cnt holds completed wait cycles, so the last allowed cycle sees MEM_TIMEOUT-1
  assign tmo   = MEM_TIMEOUT > 0 && state == MEM_WAIT && !i_mem_ready && cnt == TMO_LAST;
  always_comb begin
    nxt = RUN;
    cnt_nxt = '0;
    rcnt_nxt = '0;
    stall = 1'b0;
    lu_stall = 1'b0;
    dec_flush = 1'b0;
    ex_flush = 1'b0;
    if (hold && !tmo) begin
      stall = 1'b1;
      nxt = MEM_WAIT;
      cnt_nxt = state == MEM_WAIT ? cnt + 1'b1 : '0;
    end else if (legal && i_ex_pc_change) begin
      dec_flush = 1'b1;
      ex_flush = 1'b1;
      nxt = FLUSH_CYCLES > 1 ? REDIRECT : RUN;
      rcnt_nxt = RC_INIT;
    end else if (state == REDIRECT) begin
      dec_flush = 1'b1;
      nxt = rcnt > 2'd1 ? REDIRECT : RUN;
      rcnt_nxt = rcnt - 1'b1;
    end else if (state == RUN && hazard) begin
      lu_stall = 1'b1;
      ex_flush = 1'b1;
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= RUN;
      cnt <= '0;
      rcnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      rcnt <= rcnt_nxt;
    end
  end
  assign o_fetch_stall = i_reset_n && (stall || lu_stall);
  assign o_dec_stall   = i_reset_n && (stall || lu_stall);
  assign o_ex_stall    = i_reset_n && stall;
  assign o_mem_stall   = i_reset_n && stall;
  assign o_dec_flush   = !i_reset_n || dec_flush;
  assign o_ex_flush    = !i_reset_n || ex_flush;
  assign o_mem_err     = i_reset_n && tmo;
  assign o_state       = state;
endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// tb_rv_pipe_ctrl: directed and randomized checks of two configurations against a behavioural model
module tb_rv_pipe_ctrl;
  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  logic [4:0] i_dec_rs1 = '0, i_dec_rs2 = '0, i_ex_rd = '0;
  logic i_ex_mem_read = 1'b0, i_ex_pc_change = 1'b0, i_mem_req = 1'b0, i_mem_ready = 1'b0;
  logic [1:0] fs, ds, df, es, ef, ms, me;
  logic [1:0] st [2];
  int errs = 0, checks = 0;
  int fl_p [2] = '{3, 1};
  int tmo_p [2] = '{16, 0};
  bit in_wait [2], n_wait [2];
  int waited [2], n_waited [2], left [2], n_left [2];

  always #5 i_clk = ~i_clk;

  rv_pipe_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(16), .TMO_W(5)) dut_a (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2),
    .i_ex_rd(i_ex_rd), .i_ex_mem_read(i_ex_mem_read), .i_ex_pc_change(i_ex_pc_change),
    .i_mem_req(i_mem_req), .i_mem_ready(i_mem_ready), .o_fetch_stall(fs[0]), .o_dec_stall(ds[0]),
    .o_dec_flush(df[0]), .o_ex_stall(es[0]), .o_ex_flush(ef[0]), .o_mem_stall(ms[0]),
    .o_mem_err(me[0]), .o_state(st[0])
  );
  rv_pipe_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(0), .TMO_W(5)) dut_b (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2),
    .i_ex_rd(i_ex_rd), .i_ex_mem_read(i_ex_mem_read), .i_ex_pc_change(i_ex_pc_change),
    .i_mem_req(i_mem_req), .i_mem_ready(i_mem_ready), .o_fetch_stall(fs[1]), .o_dec_stall(ds[1]),
    .o_dec_flush(df[1]), .o_ex_stall(es[1]), .o_ex_flush(ef[1]), .o_mem_stall(ms[1]),
    .o_mem_err(me[1]), .o_state(st[1])
  );

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%b exp=%b (fs ds df es ef ms err st)", tag, got, exp);
    end
  endtask

  // Model view: are we waiting on memory, how long, and how many extra decode flushes remain
  task automatic model(input int k, output logic [8:0] e);
    logic f_s, d_s, d_f, e_s, e_f, m_s, m_e, hold, tmo, lu;
    logic [1:0] s;
    {f_s, d_s, d_f, e_s, e_f, m_s, m_e} = '0;
    if (!i_reset_n) begin
      in_wait[k] = 0; waited[k] = 0; left[k] = 0;
      n_wait[k] = 0; n_waited[k] = 0; n_left[k] = 0;
      e = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
      return;
    end
    hold = in_wait[k] ? !i_mem_ready : (i_mem_req && !i_mem_ready);
    tmo = in_wait[k] && !i_mem_ready && tmo_p[k] > 0 && waited[k] + 1 == tmo_p[k];
    lu = i_ex_mem_read && i_ex_rd != 0 && (i_ex_rd == i_dec_rs1 || i_ex_rd == i_dec_rs2);
    s = in_wait[k] ? 2'd1 : left[k] > 0 ? 2'd2 : 2'd0;
    n_wait[k] = 0; n_waited[k] = 0; n_left[k] = 0;
    if (hold && !tmo) begin
      {f_s, d_s, e_s, m_s} = 4'hf;
      n_wait[k] = 1;
      n_waited[k] = in_wait[k] ? waited[k] + 1 : 0;
    end else begin
      m_e = tmo;
      if (i_ex_pc_change) begin
        d_f = 1; e_f = 1; n_left[k] = fl_p[k] - 1;
      end else if (left[k] > 0) begin
        d_f = 1; n_left[k] = left[k] - 1;
      end else if (!in_wait[k] && lu) begin
        f_s = 1; d_s = 1; e_f = 1;
      end
    end
    e = {f_s, d_s, d_f, e_s, e_f, m_s, m_e, s};
  endtask

  task automatic tick(input string tag);
    logic [8:0] e;
    #3;
    for (int k = 0; k < 2; k++) begin
      model(k, e);
      check({tag, k == 0 ? "/a" : "/b"}, {fs[k], ds[k], df[k], es[k], ef[k], ms[k], me[k], st[k]}, e);
    end
    @(posedge i_clk);
    for (int k = 0; k < 2; k++) begin
      in_wait[k] = n_wait[k]; waited[k] = n_waited[k]; left[k] = n_left[k];
    end
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, rs2, rd, input logic ld, pc, req, rdy);
    i_dec_rs1 = rs1; i_dec_rs2 = rs2; i_ex_rd = rd;
    i_ex_mem_read = ld; i_ex_pc_change = pc; i_mem_req = req; i_mem_ready = rdy;
  endtask

  initial begin
    tick("reset");
    tick("reset");
    i_reset_n = 1'b1;
    drive(5'd1, 5'd5, 5'd5, 1, 0, 0, 0); tick("loaduse");
    drive(5'd1, 5'd5, 5'd5, 0, 0, 0, 0); tick("loaduse_clear");
    drive(5'd0, 5'd0, 5'd0, 1, 0, 0, 0); tick("loaduse_rd0");
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    repeat (3) tick("memwait");
    i_mem_ready = 1'b1; tick("memready");
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0); tick("memdone");
    i_mem_req = 1'b1;
    repeat (20) tick("watchdog");
    i_mem_req = 1'b0; i_mem_ready = 1'b1; tick("watchdog_end");
    i_mem_req = 1'b1; i_mem_ready = 1'b0;
    repeat (8) tick("prereset");
    i_reset_n = 1'b0;
    repeat (2) tick("midreset");
    i_reset_n = 1'b1;
    repeat (18) tick("postreset_wd");
    drive(5'd0, 5'd0, 5'd0, 0, 1, 0, 0); tick("redir");
    i_ex_pc_change = 1'b0; tick("redir");
    i_ex_pc_change = 1'b1; tick("redir_again");
    i_ex_pc_change = 1'b0;
    repeat (4) tick("redir_tail");
    drive(5'd3, 5'd0, 5'd3, 1, 1, 1, 0);
    repeat (2) tick("combo_hold");
    i_mem_ready = 1'b1; tick("combo_ready");
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0); tick("combo_after");
    for (int n = 0; n < 3000; n++) begin
      i_reset_n = $urandom_range(0, 199) != 0;
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick("rnd");
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
